// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_addsub_ctrl                                                         |
// | Bit-serial add/sub sequencer driving one external 1-bit add/sub cell.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_c,
  input  logic             cell_sum,
  input  logic             cell_carry,
  input  logic             cell_borrow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_run;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_res_next;

  // Cell operands are presented only while a word is being processed.
  assign w_run        = (r_state == S_RUN);
  assign cell_a       = w_run & r_a_sh[0];
  assign cell_b       = w_run & r_b_sh[0];
  assign cell_c       = w_run & r_carry;
  assign w_carry_next = r_op ? cell_borrow : cell_carry;
  assign w_res_next   = {cell_sum, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_op    <= op;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res_sh <= w_res_next;
          r_carry  <= w_carry_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          // Last bit: publish the word; result/cout are untouched otherwise.
          if (r_cnt == C_LAST) begin
            result  <= w_res_next;
            cout    <= w_carry_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
